// File: rtl/ita_gelu_ctrl_pkg.sv
// Shared types for the GELU activation stage: lane widths, GELU constants,
// activation mode and controller state, plus sign-extension helpers.
package ita_gelu_ctrl_pkg;

  localparam int unsigned WI                   = 8;
  localparam int unsigned GELU_CONSTANTS_WIDTH = 16;
  localparam int unsigned GELU_OUT_WIDTH       = 26;

  typedef logic signed [WI-1:0]                   requant_t;
  typedef logic signed [GELU_CONSTANTS_WIDTH-1:0] gelu_const_t;
  typedef logic signed [GELU_OUT_WIDTH-1:0]       gelu_out_t;

  typedef enum logic [1:0] {
    IDENTITY = 2'd0,
    RELU     = 2'd1,
    GELU     = 2'd2
  } act_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } ctrl_state_e;

  function automatic gelu_out_t sext_requant(input requant_t x);
    return {{(GELU_OUT_WIDTH-WI){x[WI-1]}}, x};
  endfunction

  function automatic gelu_out_t sext_const(input gelu_const_t k);
    return {{(GELU_OUT_WIDTH-GELU_CONSTANTS_WIDTH){k[GELU_CONSTANTS_WIDTH-1]}}, k};
  endfunction

endpackage

// File: rtl/ita_gelu.sv
// Combinational GELU lane: x * (sign(x) * ((min(|x|, -b) + b)^2 + c) + one),
// evaluated in the output width with wrap-around on overflow.
module ita_gelu
  import ita_gelu_ctrl_pkg::*;
(
  input  gelu_const_t one_i,
  input  gelu_const_t b_i,
  input  gelu_const_t c_i,
  input  requant_t    data_i,
  output gelu_out_t   result_o
);

  gelu_out_t x_ext;
  gelu_out_t abs_x;
  gelu_out_t neg_b;
  gelu_out_t clip;
  gelu_out_t d;
  gelu_out_t poly;
  gelu_out_t poly_signed;

  always_comb begin
    x_ext       = sext_requant(data_i);
    abs_x       = data_i[WI-1] ? -x_ext : x_ext;
    neg_b       = -sext_const(b_i);
    clip        = (abs_x > neg_b) ? neg_b : abs_x;
    d           = clip + sext_const(b_i);
    poly        = d * d + sext_const(c_i);
    poly_signed = data_i[WI-1] ? -poly : poly;
    result_o    = x_ext * (poly_signed + sext_const(one_i));
  end

endmodule

// File: rtl/ita_gelu_ctrl.sv
// Job-level GELU controller: latches constants per job, streams cfg_len beats
// through N lanes into one output register. ITA_GELU_BYPASS_EN enables IDENTITY/RELU.
module ita_gelu_ctrl
  import ita_gelu_ctrl_pkg::*;
#(
  parameter int unsigned N     = 16,
  parameter int unsigned LEN_W = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cfg_valid_i,
  output logic                  cfg_ready_o,
  input  gelu_const_t           cfg_one_i,
  input  gelu_const_t           cfg_b_i,
  input  gelu_const_t           cfg_c_i,
  input  act_mode_e             cfg_mode_i,
  input  logic [LEN_W-1:0]      cfg_len_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  requant_t [N-1:0]      in_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output gelu_out_t [N-1:0]     out_data_o,
  output logic                  out_last_o,
  output logic                  busy_o,
  output logic                  done_o
);

  ctrl_state_e          state_q, state_d;
  gelu_const_t          one_q, one_d, b_q, b_d, c_q, c_d;
  logic [LEN_W-1:0]     len_q, len_d, in_cnt_q, in_cnt_d;
  logic                 out_valid_q, out_valid_d;
  gelu_out_t [N-1:0]    out_data_q, out_data_d;
  logic                 out_last_q, out_last_d;
  logic                 done_q, done_d;
  gelu_out_t [N-1:0]    gelu_res, act_res;
  logic                 in_hs, out_hs, last_in;

  assign in_hs   = in_valid_i && in_ready_o;
  assign out_hs  = out_valid_q && out_ready_i;
  assign last_in = (in_cnt_q == len_q - LEN_W'(1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      one_q       <= '0;
      b_q         <= '0;
      c_q         <= '0;
      len_q       <= '0;
      in_cnt_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      one_q       <= one_d;
      b_q         <= b_d;
      c_q         <= c_d;
      len_q       <= len_d;
      in_cnt_q    <= in_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end

  // Constants only move on config acceptance, so they are stable for the whole job.
  always_comb begin
    state_d  = state_q;
    one_d    = one_q;
    b_d      = b_q;
    c_d      = c_q;
    len_d    = len_q;
    in_cnt_d = in_cnt_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_valid_i && cfg_ready_o) begin
          one_d    = cfg_one_i;
          b_d      = cfg_b_i;
          c_d      = cfg_c_i;
          len_d    = cfg_len_i;
          in_cnt_d = '0;
          state_d  = (cfg_len_i == '0) ? ST_DRAIN : ST_RUN;
        end
      end
      ST_RUN: begin
        if (in_hs) begin
          in_cnt_d = in_cnt_q + LEN_W'(1);
          if (last_in) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!out_valid_q || out_hs) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Holding off config while done is high makes the cycle after done the earliest accept.
  always_comb begin
    cfg_ready_o = (state_q == ST_IDLE) && !done_q;
    in_ready_o  = (state_q == ST_RUN) && (!out_valid_q || out_ready_i);
    busy_o      = (state_q != ST_IDLE);
    out_valid_o = out_valid_q;
    out_data_o  = out_data_q;
    out_last_o  = out_last_q;
    done_o      = done_q;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    if (in_hs) begin
      out_valid_d = 1'b1;
      out_data_d  = act_res;
      out_last_d  = last_in;
    end else if (out_hs) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    ita_gelu u_gelu (
      .one_i    (one_q),
      .b_i      (b_q),
      .c_i      (c_q),
      .data_i   (in_data_i[i]),
      .result_o (gelu_res[i])
    );
  end

`ifdef ITA_GELU_BYPASS_EN
  act_mode_e mode_q, mode_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) mode_q <= IDENTITY;
    else       mode_q <= mode_d;
  end

  always_comb begin
    mode_d = mode_q;
    if (state_q == ST_IDLE && cfg_valid_i && cfg_ready_o) mode_d = cfg_mode_i;
  end

  always_comb begin
    act_res = gelu_res;
    for (int i = 0; i < N; i++) begin
      case (mode_q)
        IDENTITY: act_res[i] = sext_requant(in_data_i[i]);
        RELU:     act_res[i] = in_data_i[i][WI-1] ? '0 : sext_requant(in_data_i[i]);
        default:  act_res[i] = gelu_res[i];
      endcase
    end
  end
`else
  logic unused_mode;
  assign unused_mode = ^cfg_mode_i;
  assign act_res     = gelu_res;
`endif

endmodule

// File: tb/tb_ita_gelu_ctrl.sv
// Self-checking bench for ita_gelu_ctrl: directed jobs plus an arithmetic
// reference model checked every cycle. IDENTITY/RELU tests need ITA_GELU_BYPASS_EN.
module tb_ita_gelu_ctrl;
  import ita_gelu_ctrl_pkg::*;

  localparam int N     = 16;
  localparam int LEN_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  gelu_const_t       cfg_one = '0, cfg_b = '0, cfg_c = '0;
  act_mode_e         cfg_mode = GELU;
  logic [LEN_W-1:0]  cfg_len = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  requant_t [N-1:0]  in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  gelu_out_t [N-1:0] out_data;
  logic              out_last;
  logic              busy;
  logic              done;

  always #5 clk = ~clk;

  ita_gelu_ctrl #(.N(N), .LEN_W(LEN_W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cfg_valid_i (cfg_valid),
    .cfg_ready_o (cfg_ready),
    .cfg_one_i   (cfg_one),
    .cfg_b_i     (cfg_b),
    .cfg_c_i     (cfg_c),
    .cfg_mode_i  (cfg_mode),
    .cfg_len_i   (cfg_len),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_last_o  (out_last),
    .busy_o      (busy),
    .done_o      (done)
  );

  typedef struct {
    int d[N];
    bit last;
  } beat_t;

  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  beat_t exp_q[$];
  int    log_lane0[$];
  bit    log_last[$];
  int    log_cyc[$];

  // Reference model state: what the controller should be doing this job
  int        job_one = 0, job_b = 0, job_c = 0, job_len = 0, job_idx = 0;
  act_mode_e job_mode = GELU;
  bit        model_busy = 0;
  int        done_cnt = 0;
  bit        stall_prev = 0;
  gelu_out_t [N-1:0] data_prev = '0;
  logic      last_prev = 1'b0;

  function automatic int wrap26(input longint v);
    longint m;
    m = v & 64'h3FF_FFFF;
    if (m >= 64'sh200_0000) m = m - 64'sh400_0000;
    return int'(m);
  endfunction

  // Plain-integer activation, wrapped to the 26-bit output at the end
  function automatic int act_ref(input int x, input int one, input int b, input int c,
                                 input act_mode_e mode);
    longint ax, nb, clip, dd, l;
    bit bypass;
    bypass = 1'b0;
`ifdef ITA_GELU_BYPASS_EN
    bypass = 1'b1;
`endif
    if (bypass && mode == IDENTITY) return x;
    if (bypass && mode == RELU) return (x < 0) ? 0 : x;
    ax   = (x < 0) ? -longint'(x) : longint'(x);
    nb   = -longint'(b);
    clip = (ax > nb) ? nb : ax;
    dd   = clip + b;
    l    = dd * dd + c;
    if (x < 0) l = -l;
    return wrap26(longint'(x) * (l + one));
  endfunction

  function automatic int lane_val(input int x, input int i);
    int t;
    if (i == 0) return x;
    t = (x + 13 * i) & 255;
    return (t > 127) ? t - 256 : t;
  endfunction

  task automatic checkOutput(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Cycle-level compare process: the model decides every handshake on its own
  always @(negedge clk) begin
    bit exp_done, exp_valid, exp_in_ready, exp_cfg_ready;
    cyc++;
    if (rst) begin
      exp_q.delete();
      model_busy = 0;
      done_cnt   = 0;
      stall_prev = 0;
      job_idx    = 0;
      job_len    = 0;
    end else begin
      exp_done = (done_cnt == 1);
      if (done_cnt > 0) done_cnt--;
      if (exp_done) model_busy = 0;
      exp_valid     = (exp_q.size() > 0);
      exp_in_ready  = model_busy && (job_idx < job_len) && (!exp_valid || out_ready);
      exp_cfg_ready = !model_busy && !exp_done;

      checks++;
      if ({done, out_valid, busy, in_ready, cfg_ready} !==
          {exp_done, exp_valid, model_busy, exp_in_ready, exp_cfg_ready}) begin
        failures++;
        $display("[TB] FAIL ctrl cyc%0d {done,valid,busy,in_rdy,cfg_rdy}: actual=%b required=%b",
                 cyc, {done, out_valid, busy, in_ready, cfg_ready},
                 {exp_done, exp_valid, model_busy, exp_in_ready, exp_cfg_ready});
      end

      if (stall_prev) begin
        checks++;
        if (out_data !== data_prev || out_last !== last_prev) begin
          failures++;
          $display("[TB] FAIL hold cyc%0d: actual lane0=%0d last=%b required lane0=%0d last=%b",
                   cyc, $signed(out_data[0]), out_last, $signed(data_prev[0]), last_prev);
        end
      end

      if (exp_valid && out_ready) begin
        beat_t e;
        int bad;
        e = exp_q.pop_front();
        bad = -1;
        for (int i = 0; i < N; i++)
          if (bad < 0 && int'($signed(out_data[i])) != e.d[i]) bad = i;
        checks++;
        if (bad >= 0 || out_last !== e.last) begin
          if (bad < 0) bad = 0;
          failures++;
          $display("[TB] FAIL beat cyc%0d lane%0d: actual=%0d last=%b required=%0d last=%b",
                   cyc, bad, $signed(out_data[bad]), out_last, e.d[bad], e.last);
        end
        log_lane0.push_back(int'($signed(out_data[0])));
        log_last.push_back(out_last);
        log_cyc.push_back(cyc);
        if (e.last) done_cnt = 1;
      end

      if (in_valid && exp_in_ready) begin
        beat_t nb;
        for (int i = 0; i < N; i++)
          nb.d[i] = act_ref(int'($signed(in_data[i])), job_one, job_b, job_c, job_mode);
        nb.last = (job_idx == job_len - 1);
        job_idx++;
        exp_q.push_back(nb);
      end

      if (cfg_valid && exp_cfg_ready) begin
        job_one    = int'(cfg_one);
        job_b      = int'(cfg_b);
        job_c      = int'(cfg_c);
        job_mode   = cfg_mode;
        job_len    = int'(cfg_len);
        job_idx    = 0;
        model_busy = 1;
        if (job_len == 0) done_cnt = 2;
      end

      stall_prev = exp_valid && !out_ready;
      data_prev  = out_data;
      last_prev  = out_last;
    end
  end

  // All driving tasks start and end at posedge+1
  task automatic do_config(input int one, input int b, input int c, input act_mode_e mode,
                           input int len);
    int n;
    n = 0;
    cfg_valid = 1'b1;
    cfg_one   = gelu_const_t'(one);
    cfg_b     = gelu_const_t'(b);
    cfg_c     = gelu_const_t'(c);
    cfg_mode  = mode;
    cfg_len   = LEN_W'(len);
    do begin @(negedge clk); n++; end while (!cfg_ready && n < 50);
    if (!cfg_ready) checkOutput("cfg_accept_timeout", 0, 1);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic applyStimulus(input int x);
    int n;
    n = 0;
    in_valid = 1'b1;
    for (int i = 0; i < N; i++) in_data[i] = requant_t'(lane_val(x, i));
    do begin @(negedge clk); n++; end while (!in_ready && n < 50);
    if (!in_ready) checkOutput("in_accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!done && n < 50);
    checkOutput("done_seen", int'(done), 1);
    @(posedge clk); #1;
  endtask

  task automatic clear_log();
    log_lane0.delete();
    log_last.delete();
    log_cyc.delete();
  endtask

  task automatic check_lane0(input string name, input int v0, input int v1, input int v2);
    checkOutput({name, "_count"}, log_lane0.size(), 3);
    if (log_lane0.size() == 3) begin
      checkOutput({name, "_b0"}, log_lane0[0], v0);
      checkOutput({name, "_b1"}, log_lane0[1], v1);
      checkOutput({name, "_b2"}, log_lane0[2], v2);
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_out_data_zero", int'(out_data == '0), 1);
    checkOutput("rst_out_last", int'(out_last), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_in_ready", int'(in_ready), 0);
    checkOutput("rst_cfg_ready", int'(cfg_ready), 1);
    @(posedge clk); #1;
    rst = 1'b0;

    $display("[TB] test 1: GELU job, full throughput");
    clear_log();
    do_config(1, -2, 1, GELU, 3);
    applyStimulus(3);
    applyStimulus(1);
    applyStimulus(-3);
    wait_done();
    check_lane0("t1_lane0", 6, 3, 0);
    if (log_last.size() == 3) begin
      checkOutput("t1_last_flags", int'({log_last[0], log_last[1], log_last[2]}), 1);
      checkOutput("t1_gap01", log_cyc[1] - log_cyc[0], 1);
      checkOutput("t1_gap12", log_cyc[2] - log_cyc[1], 1);
    end

    $display("[TB] test 2: output stall mid-stream");
    clear_log();
    do_config(1, -2, 1, GELU, 3);
    applyStimulus(3);
    out_ready = 1'b0;
    fork
      applyStimulus(1);
      begin
        repeat (4) begin
          @(negedge clk);
          checkOutput("t2_in_ready_low", int'(in_ready), 0);
          checkOutput("t2_held_lane0", int'($signed(out_data[0])), 6);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    applyStimulus(-3);
    wait_done();
    check_lane0("t2_lane0", 6, 3, 0);

    $display("[TB] test 3: zero-length job");
    clear_log();
    do_config(0, 0, 0, GELU, 0);
    @(negedge clk);
    checkOutput("t3_busy_c1", int'(busy), 1);
    checkOutput("t3_done_c1", int'(done), 0);
    @(negedge clk);
    checkOutput("t3_busy_c2", int'(busy), 0);
    checkOutput("t3_done_c2", int'(done), 1);
    @(negedge clk);
    checkOutput("t3_done_c3", int'(done), 0);
    checkOutput("t3_no_beats", log_lane0.size(), 0);
    @(posedge clk); #1;

`ifdef ITA_GELU_BYPASS_EN
    $display("[TB] test 4: RELU and IDENTITY bypass");
    clear_log();
    do_config(1, -2, 1, RELU, 3);
    applyStimulus(-128);
    applyStimulus(0);
    applyStimulus(127);
    wait_done();
    check_lane0("t4_relu", 0, 0, 127);
    clear_log();
    do_config(1, -2, 1, IDENTITY, 3);
    applyStimulus(-128);
    applyStimulus(0);
    applyStimulus(127);
    wait_done();
    check_lane0("t4_ident", -128, 0, 127);
`endif

    $display("[TB] test 5: config attempt during RUN");
    clear_log();
    do_config(1, -2, 1, GELU, 3);
    applyStimulus(3);
    cfg_valid = 1'b1;
    cfg_one   = 16'sd5;
    cfg_b     = -16'sd7;
    cfg_c     = 16'sd9;
    cfg_len   = LEN_W'(2);
    @(negedge clk);
    checkOutput("t5_cfg_ready_low", int'(cfg_ready), 0);
    @(posedge clk); #1;
    applyStimulus(1);
    cfg_valid = 1'b0;
    applyStimulus(-3);
    wait_done();
    check_lane0("t5_lane0", 6, 3, 0);

    $display("[TB] test 6: reset mid-job");
    clear_log();
    do_config(1, -2, 1, GELU, 5);
    applyStimulus(3);
    applyStimulus(1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("t6_out_valid", int'(out_valid), 0);
    checkOutput("t6_busy", int'(busy), 0);
    checkOutput("t6_cfg_ready", int'(cfg_ready), 1);
    checkOutput("t6_done", int'(done), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      checkOutput("t6_no_done", int'(done), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ita_gelu_ctrl.md
# ita_gelu_ctrl

Job-level controller for the GELU activation stage. It latches the GELU constants and the activation mode once per job. It then streams a fixed number of N-lane requantized beats through N parallel `ita_gelu` lanes, with one output register stage and full valid/ready backpressure. It sits between the requantizer output and the activation write-back path, and signals job completion to the top-level controller.

## Interface
- `N`, 16, number of parallel activation lanes per beat
- `LEN_W`, 16, width of the beat counter and job length
- `clk_i`  in  1  clock
- `rst_i`  in  1  reset; synchronous, active-high
- `cfg_valid_i`  in  1  job configuration valid
- `cfg_ready_o`  out  1  controller accepts a configuration (high only in IDLE)
- `cfg_one_i`  in  gelu_const_t  GELU "one" constant
- `cfg_b_i`  in  gelu_const_t  GELU clip/offset constant
- `cfg_c_i`  in  gelu_const_t  GELU polynomial constant
- `cfg_mode_i`  in  act_mode_e  IDENTITY / RELU / GELU
- `cfg_len_i`  in  LEN_W  beats in the job
- `in_valid_i`  in  1  input beat valid
- `in_ready_o`  out  1  input beat accepted
- `in_data_i`  in  N x requant_t  signed input lanes
- `out_valid_o`  out  1  output beat valid
- `out_ready_i`  in  1  downstream accepts
- `out_data_o`  out  N x gelu_out_t  activated lanes
- `out_last_o`  out  1  marks the final beat of the job
- `busy_o`  out  1  state != IDLE
- `done_o`  out  1  one-cycle pulse once the last beat has left

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE
  - `cfg_ready_o` = 1.
  - On `cfg_valid_i`, latch one/b/c/mode/len, clear `in_cnt`, then:
    - go to RUN if len > 0;
    - go to DRAIN if len == 0.
- RUN
  - `in_ready_o` = `!out_valid_o || out_ready_i`.
  - Each input handshake increments `in_cnt`.
  - The handshake with `in_cnt == len-1` loads `out_last_o` = 1 with that beat and moves the FSM to DRAIN.
- DRAIN
  - `in_ready_o` = 0.
  - When the output register is empty (`!out_valid_o`, or the last beat handshakes this cycle), pulse `done_o` in the following cycle and return to IDLE.
  - For len == 0, `done_o` pulses one cycle after config acceptance; no output beats are produced.
- Configuration outside IDLE is ignored (`cfg_ready_o` = 0). Latched constants stay stable for the whole job.
- Lane arithmetic, per lane:
  - GELU: sign-extend x; take |x|; clip to -b; d = clip + b; L = d² + c; apply the sign of x to L; add one; multiply by x.
  - All results are in gelu_out_t width; wrap on overflow, no saturation.
  - RELU: out = x < 0 ? 0 : sign-extended x.
  - IDENTITY: out = sign-extended x.
- Output register: loads on an input handshake; holds while `out_valid_o && !out_ready_i`; clears valid when it is drained with no new load.
- Simultaneous output drain and input load in the same cycle is allowed (full throughput).
- Reset mid-job: aborts the job, empties the pipeline, returns to IDLE. No `done_o` is issued.

## Timing
- Reset values:
  - `out_valid_o` = 0, `out_data_o` = 0, `out_last_o` = 0, `done_o` = 0, `busy_o` = 0.
  - `in_ready_o` = 0, `cfg_ready_o` = 1 (IDLE).
  - Internal counters and constants = 0.
- Input-to-output latency: 1 cycle. The beat accepted in cycle t is valid in cycle t+1.
- Throughput: one beat per cycle while `out_ready_i` stays high.
- `done_o` is asserted exactly one cycle after the `out_last_o` handshake.
- The earliest next configuration acceptance is the cycle after `done_o`.
- `out_data_o` and `out_last_o` must not change while `out_valid_o && !out_ready_i`.
- Reset has priority over every other event in the same cycle.

## Configuration
- Macro: `ITA_GELU_BYPASS_EN`.
- Defined: `cfg_mode_i` is honoured, and IDENTITY and RELU are available.
- Undefined: `cfg_mode_i` is ignored, every lane computes GELU, and no mode register or bypass mux is synthesized.

## Structure
- Shared package holds:
  - `act_mode_e` (2-bit enum: IDENTITY=0, RELU=1, GELU=2);
  - the existing `requant_t`, `gelu_const_t`, `gelu_out_t`, WI, GELU_CONSTANTS_WIDTH, GELU_OUT_WIDTH.
- Sub-module: N instances of the existing `ita_gelu` combinational lane. Mode muxing and the output register live in `ita_gelu_ctrl`.

## Test plan
1. Config: mode=GELU, one=1, b=-2, c=1, len=3. Stream lanes x=3, 1, -3, with `out_ready_i` held high.
   - Required: outputs 6, 3, 0 on consecutive cycles.
   - Required: `out_last_o` is set only on the third output beat.
   - Required: `done_o` pulses one cycle after that beat.
2. Same job, with `out_ready_i` low for 4 cycles mid-stream.
   - Required: `in_ready_o` drops and the output data is held stable.
   - Required: no beat is lost or duplicated; exactly 3 output beats.
3. len=0 configuration.
   - Required: no `out_valid_o`; `done_o` one cycle after acceptance; `busy_o` high for exactly 1 cycle.
4. With `ITA_GELU_BYPASS_EN`, mode=RELU, inputs -128, 0, 127.
   - Required: outputs 0, 0, 127.
   - Required: with mode=IDENTITY the outputs are -128, 0, 127.
5. Assert `cfg_valid_i` during RUN with different constants.
   - Required: `cfg_ready_o` = 0 and the outputs still use the original constants.
6. Assert `rst_i` in the cycle after the 2nd beat of a len=5 job.
   - Required: next cycle `out_valid_o` = 0, FSM in IDLE, `cfg_ready_o` = 1, and no `done_o` pulse.
